decoder_pipe: RTL and testbench
===============================

DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter W, default 5: input code width; legal range 1..6.
REQ-002 Parameter MASK, N bits, default 1: output lines forced to 0; default suppresses line 0 (x0). N = 2**W.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 IN_VALID  input  1  request strobe.
REQ-006 IN_READY  output  1  block can accept a request.
REQ-007 IN  input  W  code to decode.
REQ-008 MODE  input  2  00 one-hot, 01 thermometer, 10 sweep, 11 reserved.
REQ-009 OUT_VALID  output  1  OUT carries a result this cycle.
REQ-010 OUT  output  N  registered decoded lines.
REQ-011 BUSY  output  1  sweep in progress.
REQ-012 DONE  output  1  final sweep output is present.
REQ-013 ERR  output  1  sticky flag: a reserved mode was accepted.

Function
REQ-014 FSM states: IDLE and SWEEP.
REQ-015 IN_READY = 1 in IDLE and 0 in SWEEP; BUSY = 1 exactly when in SWEEP; both decode combinationally from state.
REQ-016 Accept = IN_VALID & IN_READY, sampled at the rising edge; IN and MODE are ignored when no accept occurs.
REQ-017 MODE 00 accept: next cycle OUT = (1 << IN) & ~MASK and OUT_VALID = 1, for one cycle; latency 1.
REQ-018 MODE 01 accept: next cycle OUT bits [IN:0] = 1, others 0, then & ~MASK; OUT_VALID = 1 for one cycle.
REQ-019 MODE 11 accept: next cycle OUT = 0 and OUT_VALID = 1; ERR sets and holds until reset.
REQ-020 MODE 10 accept in IDLE (edge k): go to SWEEP, W-bit counter = 0, OUT = (1 << 0) & ~MASK, OUT_VALID = 1.
REQ-021 Each edge in SWEEP with counter < N-1: counter increments and OUT = (1 << counter) & ~MASK, using the new counter value.
REQ-022 Sweep outputs appear in cycles k+1..k+N, one line per cycle in ascending order, with OUT_VALID = 1 throughout.
REQ-023 DONE is registered and is 1 only in the cycle where the counter is N-1.
REQ-024 Edge in SWEEP with counter = N-1: go to IDLE with OUT = 0, OUT_VALID = 0, DONE = 0; IN_READY = 1 from cycle k+N+1.
REQ-025 IN_VALID during SWEEP is ignored: no queueing and no effect on the sweep.
REQ-026 IDLE edge with no accept: OUT = 0 and OUT_VALID = 0, so single-cycle results return to zero.
REQ-027 Back-to-back accepts in IDLE (modes 00/01/11) give one result per cycle with no bubble.
REQ-028 A fully masked result (OUT = 0) still asserts OUT_VALID.
REQ-029 OUT never drives a MASK bit to 1 in any mode.

Reset
REQ-030 RST_N low asynchronously forces IDLE, counter = 0, OUT = 0, OUT_VALID = 0, DONE = 0 and ERR = 0, giving IN_READY = 1 and BUSY = 0.
REQ-031 Reset during SWEEP aborts it immediately; DONE is not emitted for the aborted sweep.
REQ-032 The first accept is possible on the first rising edge after RST_N deasserts.

Verification (W=5, MASK=1)
REQ-033 MODE=00, IN=3, one-cycle IN_VALID -> next cycle OUT=0x00000008 with OUT_VALID=1; cycle after: OUT=0, OUT_VALID=0.
REQ-034 MODE=00, IN=0 -> OUT=0x00000000 with OUT_VALID=1; MODE=01, IN=4 -> OUT=0x0000001E.
REQ-035 MODE=00 with IN=31 then IN=5 on consecutive cycles -> OUT=0x80000000 then 0x00000020 on consecutive cycles.
REQ-036 MODE=10 -> 32 cycles of OUT 0x0, 0x2, 0x4 ... 0x80000000 with BUSY=1 and IN_READY=0; DONE=1 only with 0x80000000; IN_VALID held high during the sweep has no effect; IN_READY=1 on the following cycle.
REQ-037 RST_N pulsed low mid-sweep at count 10 -> OUT=0, BUSY=0, DONE=0 without waiting for a clock edge; after release, MODE=00, IN=31 -> OUT=0x80000000.
REQ-038 MODE=11 accept -> OUT=0 with OUT_VALID=1 and ERR=1; ERR stays 1 through later requests until reset.

Source files
------------

// File: rtl/decoder_pipe.sv
// Registered W-to-2**W line decoder with one-hot, thermometer and line-sweep modes.
// MASK bits are forced low on every result; a reserved mode sets a sticky error.
module decoder_pipe #(
  parameter int W = 5,
  parameter logic [(1<<W)-1:0] MASK = {{((1<<W)-1){1'b0}}, 1'b1}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in,
  input  logic [1:0]         mode,
  output logic               out_valid,
  output logic [(1<<W)-1:0]  out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int N = 1 << W;
  localparam logic [W-1:0] CNT_LAST = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   cnt_p1, cnt_nx, cnt_inc;
  logic [N-1:0]   out_p1, out_nx;
  logic           vld_p1, vld_nx;
  logic           done_p1, done_nx;
  logic           err_p1, err_nx;
  logic           accept;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r & ~MASK;
  endfunction

  function automatic logic [N-1:0] thermo(input logic [W-1:0] idx);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (i <= int'(idx));
    return r & ~MASK;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state == SWEEP);
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt_p1 + 1'b1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_p1;
    out_nx   = '0;
    vld_nx   = 1'b0;
    done_nx  = 1'b0;
    err_nx   = err_p1;
    case (state)
      IDLE: begin
        if (accept) begin
          vld_nx = 1'b1;
          case (mode)
            2'b00: out_nx = onehot(in);
            2'b01: out_nx = thermo(in);
            2'b10: begin
              state_nx = SWEEP;
              cnt_nx   = '0;
              out_nx   = onehot('0);
            end
            default: err_nx = 1'b1;
          endcase
        end
      end
      SWEEP: begin
        // New requests are dropped here; in_ready is low so accept never fires.
        if (cnt_p1 != CNT_LAST) begin
          cnt_nx  = cnt_inc;
          out_nx  = onehot(cnt_inc);
          vld_nx  = 1'b1;
          done_nx = (cnt_inc == CNT_LAST);
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p1: registered result and control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt_p1  <= '0;
      out_p1  <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt_p1  <= cnt_nx;
      out_p1  <= out_nx;
      vld_p1  <= vld_nx;
      done_p1 <= done_nx;
      err_p1  <= err_nx;
    end
  end

  assign out       = out_p1;
  assign out_valid = vld_p1;
  assign done      = done_p1;
  assign err       = err_p1;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed-vector bench for decoder_pipe at W=5, MASK=1.
module tb_decoder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in;
  logic [1:0]  mode;
  logic        out_valid;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  decoder_pipe #(.W(5), .MASK(32'h1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .mode      (mode),
    .out_valid (out_valid),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] m, input logic [4:0] c);
    mode     = m;
    in       = c;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [31:0] e;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in       = '0;
    mode     = '0;
    #3;
    chk("rst_out", out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // one-hot, single request, then return to zero
    req(2'b00, 5'd3);
    tick();
    in_valid = 1'b0;
    chk("oh3_out", out, 32'h8);
    chk("oh3_vld", out_valid, 1);
    tick();
    chk("idle_out", out, 0);
    chk("idle_vld", out_valid, 0);

    // masked line 0 still valid, then thermometer back-to-back
    req(2'b00, 5'd0);
    tick();
    chk("oh0_out", out, 0);
    chk("oh0_vld", out_valid, 1);
    req(2'b01, 5'd4);
    tick();
    chk("th4_out", out, 32'h1E);
    chk("th4_vld", out_valid, 1);
    req(2'b01, 5'd31);
    tick();
    chk("th31_out", out, 32'hFFFF_FFFE);

    // consecutive one-hot results, no bubble
    req(2'b00, 5'd31);
    tick();
    chk("oh31_out", out, 32'h8000_0000);
    req(2'b00, 5'd5);
    tick();
    chk("oh5_out", out, 32'h20);
    chk("oh5_vld", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("idle2_vld", out_valid, 0);

    // full sweep with in_valid held high throughout
    req(2'b10, 5'd0);
    tick();
    req(2'b00, 5'd7);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      e = (i == 0) ? 32'h0 : (32'h1 << i);
      chk($sformatf("sw%0d_out", i), out, e);
      chk($sformatf("sw%0d_vld", i), out_valid, 1);
      chk($sformatf("sw%0d_done", i), done, (i == 31) ? 1 : 0);
      chk($sformatf("sw%0d_busy", i), busy, 1);
      chk($sformatf("sw%0d_ready", i), in_ready, 0);
    end
    tick();
    chk("swend_ready", in_ready, 1);
    chk("swend_busy", busy, 0);
    chk("swend_vld", out_valid, 0);
    chk("swend_out", out, 0);
    chk("swend_done", done, 0);
    in_valid = 1'b0;
    tick();
    chk("post_sw_vld", out_valid, 0);

    // reset aborts a sweep at count 10 without a clock edge
    req(2'b10, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sw10_out", out, 32'h400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out", out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_vld", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req(2'b00, 5'd31);
    tick();
    in_valid = 1'b0;
    chk("rel_out", out, 32'h8000_0000);
    chk("rel_vld", out_valid, 1);

    // reserved mode sets sticky error
    req(2'b11, 5'd9);
    tick();
    chk("res_out", out, 0);
    chk("res_vld", out_valid, 1);
    chk("res_err", err, 1);
    req(2'b00, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("err_hold_out", out, 32'h4);
    chk("err_hold1", err, 1);
    tick();
    chk("err_hold2", err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("err_clr", err, 0);
    #10;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
